// File: rtl/clk_div_bank_if.sv
// Configuration port of the clock divider bank: write channel, sync strobe and status.
interface clk_div_bank_if #(
  parameter int DIV_W = 16
);
  logic             cfg_wr;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_sync;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_wr, cfg_ch, cfg_div, cfg_phase, cfg_sync,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_div, cfg_phase, cfg_sync,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of refclk dividers with shadowed configuration applied at period boundaries,
// a global phase-sync strobe and a quiet-time lock indicator.
module clk_div_ch #(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 0
)(
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             sync,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             outclk,
  output logic             pending,
  output logic             applied
);
  localparam logic [DIV_W-1:0] RST_D = DIV_W'(RST_DIV);
  localparam logic [DIV_W-1:0] RST_C = (RST_DIV == 0) ? '0 : DIV_W'(RST_DIV - 1);

  logic [DIV_W-1:0] div, phase, cnt, sh_div, sh_phase;
  logic [DIV_W-1:0] div_n, phase_n, cnt_n, src_div, src_phase, half;
  logic             last;

  always_comb begin
    // a write landing with sync is captured first, so it feeds the apply directly
    src_div   = wr ? wr_div   : sh_div;
    src_phase = wr ? wr_phase : sh_phase;
    last      = (div == '0) || (cnt == div - DIV_W'(1));
    applied   = (pending && last) || (sync && (pending || wr));
    div_n     = div;
    phase_n   = phase;
    if (applied) begin
      div_n   = src_div;
      phase_n = src_phase;
      cnt_n   = src_phase;
    end else if (div == '0) begin
      cnt_n = '0;
    end else if (sync) begin
      cnt_n = phase;
    end else if (cnt == div - DIV_W'(1)) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt + DIV_W'(1);
    end
    half = div_n - (div_n >> 1);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= RST_D;
      phase    <= '0;
      cnt      <= RST_C;
      sh_div   <= '0;
      sh_phase <= '0;
      pending  <= 1'b0;
      outclk   <= 1'b0;
    end else begin
      div    <= div_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      outclk <= (cnt_n < half);
      if (wr) begin
        sh_div   <= wr_div;
        sh_phase <= wr_phase;
      end
      if (applied)  pending <= 1'b0;
      else if (wr)  pending <= 1'b1;
    end
  end
endmodule

module clk_div_bank #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 12,
  parameter int LOCK_CYCLES = 256
)(
  input  logic                  refclk,
  input  logic                  rst_n,
  clk_div_bank_if.slave         cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CLOCKS-1:0] pending, applied, ch_wr;
  logic [7:0]            pend8;
  logic                  in_range, wr_ok;
  logic [DIV_W-1:0]      wr_div, wr_phase;
  logic [LCW-1:0]        lock_cnt;

  always_comb begin
    pend8 = '0;
    pend8[NUM_CLOCKS-1:0] = pending;
  end

  assign in_range      = ({1'b0, cfg.cfg_ch} < 4'(NUM_CLOCKS));
  assign cfg.cfg_ready = in_range ? ~pend8[cfg.cfg_ch] : 1'b1;
  assign wr_ok         = cfg.cfg_wr && cfg.cfg_ready && in_range;
  assign wr_div        = (cfg.cfg_div == DIV_W'(1)) ? DIV_W'(2) : cfg.cfg_div;
  assign wr_phase      = (cfg.cfg_phase >= wr_div) ? '0 : cfg.cfg_phase;

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
    assign ch_wr[g] = wr_ok && (cfg.cfg_ch == 3'(g));
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .RST_DIV ((g == 0) ? DEFAULT_DIV : 0)
    ) u_ch (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .wr       (ch_wr[g]),
      .sync     (cfg.cfg_sync),
      .wr_div   (wr_div),
      .wr_phase (wr_phase),
      .outclk   (outclk[g]),
      .pending  (pending[g]),
      .applied  (applied[g])
    );
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_err <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      cfg.cfg_err <= cfg.cfg_wr && !in_range;
      if ((|applied) || wr_ok || cfg.cfg_sync) lock_cnt <= '0;
      else if (lock_cnt != LCW'(LOCK_CYCLES))  lock_cnt <= lock_cnt + LCW'(1);
    end
  end

  assign locked = (lock_cnt == LCW'(LOCK_CYCLES)) && !(|pending);
endmodule
